// File: rtl/usb_bus_master_if.sv
// usb_bus_master_if
//   Signal bundle between the USB debug/boot initiator and the outside world.
//   It carries two groups of signals:
//     - FT245-style FIFO: usb_din/usb_dout/usb_doe, _rdf/_rd (receive), _txe/wr (transmit)
//     - 68000-style asynchronous bus: bus_req/bus_gnt, addr, bus_dout/bus_doe/bus_din,
//       _as/_ds/rw, _dtack
//   Modports:
//     master - the initiator (drives strobes, address and FIFO controls)
//     slave  - the environment (host FIFO plus bus responder/arbiter)
interface usb_bus_master_if #(
  parameter int ADDR_W = 20
);
  logic [7:0]        usb_din;
  logic [7:0]        usb_dout;
  logic              usb_doe;
  logic              _rdf;
  logic              _rd;
  logic              _txe;
  logic              wr;
  logic              bus_req;
  logic              bus_gnt;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        bus_dout;
  logic              bus_doe;
  logic [7:0]        bus_din;
  logic              _as;
  logic              _ds;
  logic              rw;
  logic              _dtack;

  modport master (
    input  usb_din, _rdf, _txe, bus_gnt, bus_din, _dtack,
    output usb_dout, usb_doe, _rd, wr, bus_req, addr, bus_dout, bus_doe, _as, _ds, rw
  );

  modport slave (
    output usb_din, _rdf, _txe, bus_gnt, bus_din, _dtack,
    input  usb_dout, usb_doe, _rd, wr, bus_req, addr, bus_dout, bus_doe, _as, _ds, rw
  );
endinterface

// File: rtl/usb_bus_master.sv
// usb_bus_master
//   Host-side debug/boot initiator. It pulls command bytes from an FT245-style
//   USB FIFO and runs single byte read/write cycles on a 68000-style
//   asynchronous bus. It returns a status byte, followed by the data byte for
//   reads.
//   Commands:
//     57 A2 A1 A0 D : write D to {A2[3:0],A1,A0}  -> 06 (ok) / 15 (timeout)
//     52 A2 A1 A0   : read                        -> status, data
//     other         : no bus cycle                -> 3F
//   Optional macro USB_BUS_MASTER_AUTOINC_EN: opcode 4E repeats the last R/W at
//   last address + 1. It takes one data byte if the last op was a write. When
//   the macro is undefined, 4E is an unknown opcode.
//   Ports:
//     clk, _reset   clock, asynchronous active-low reset
//     u             FIFO + bus signal bundle (master modport)
//     busy          FSM not in IDLE
//     err           sticky dtack-timeout flag, cleared only by reset
module usb_bus_master #(
  parameter int ADDR_W        = 20,
  parameter int DTACK_TIMEOUT = 255,
  parameter int RD_PULSE      = 2,
  parameter int WR_PULSE      = 2
) (
  input  logic             clk,
  input  logic             _reset,
  usb_bus_master_if.master u,
  output logic             busy,
  output logic             err
);

  localparam logic [7:0] OP_W   = 8'h57;
  localparam logic [7:0] OP_R   = 8'h52;
`ifdef USB_BUS_MASTER_AUTOINC_EN
  localparam logic [7:0] OP_N   = 8'h4E;
`endif
  localparam logic [7:0] ST_OK  = 8'h06;
  localparam logic [7:0] ST_TO  = 8'h15;
  localparam logic [7:0] ST_BAD = 8'h3F;

  // Strobe-to-strobe spacing on the FIFO. It covers the 2-flop synchronizer,
  // so _rdf/_txe already reflect the previous access when they are next sampled.
  localparam int SYNC_GAP = 3;
  localparam int CNT_W    = $clog2(DTACK_TIMEOUT + RD_PULSE + WR_PULSE + SYNC_GAP + 1) + 1;

  typedef enum logic [2:0] {IDLE, FETCH, REQ, ADDR, STROBE, RELEASE, SEND} state_t;
  // Sub-phase of a FIFO byte transfer (shared by FETCH and SEND)
  typedef enum logic [2:0] {P_WAIT, P_PULSE, P_GAP, P_SETUP, P_HOLD} phase_t;

  typedef struct packed {
    state_t            state;
    phase_t            phase;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        bidx;     // command bytes fetched so far
    logic [4:0][7:0]   cmd;      // opcode, A2, A1, A0, D
    logic [7:0]        rdata;
    logic [7:0]        rep0;     // status byte
    logic              tout;
    logic              two;      // reply carries a data byte
    logic              ridx;     // reply byte being sent
    logic              err;
    logic              rd_n;
    logic              wr;
    logic              usb_doe;
    logic [7:0]        usb_dout;
    logic              bus_req;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        bus_dout;
    logic              bus_doe;
    logic              as_n;
    logic              ds_n;
    logic              rw;
  } regs_t;

  localparam regs_t R_RST = '{state: IDLE, phase: P_WAIT, cnt: '0, bidx: '0, cmd: '0,
                              rdata: '0, rep0: '0, tout: 1'b0, two: 1'b0, ridx: 1'b0,
                              err: 1'b0, rd_n: 1'b1, wr: 1'b0, usb_doe: 1'b0,
                              usb_dout: '0, bus_req: 1'b0, addr: '0, bus_dout: '0,
                              bus_doe: 1'b0, as_n: 1'b1, ds_n: 1'b1, rw: 1'b1};

  regs_t r, rn;

  // Input synchronizers, reset to the idle level of each input
  logic [1:0] rdf_sy, txe_sy, dtack_sy, gnt_sy;
  logic       rdf_s, txe_s, dtack_s, gnt_s;

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      rdf_sy   <= 2'b11;
      txe_sy   <= 2'b11;
      dtack_sy <= 2'b11;
      gnt_sy   <= 2'b00;
    end else begin
      rdf_sy   <= {rdf_sy[0],   u._rdf};
      txe_sy   <= {txe_sy[0],   u._txe};
      dtack_sy <= {dtack_sy[0], u._dtack};
      gnt_sy   <= {gnt_sy[0],   u.bus_gnt};
    end
  end

  assign rdf_s   = rdf_sy[1];
  assign txe_s   = txe_sy[1];
  assign dtack_s = dtack_sy[1];
  assign gnt_s   = gnt_sy[1];

`ifdef USB_BUS_MASTER_AUTOINC_EN
  // Last executed bus op. The reset value makes the first 4E read address 0.
  logic              last_w;
  logic [ADDR_W-1:0] last_addr;
`endif

  // The full 24-bit address from the command; bits above ADDR_W are dropped
  logic [23:0] a24;
  logic        unused_a24;
  assign a24        = {r.cmd[1], r.cmd[2], r.cmd[3]};
  assign unused_a24 = ^a24;

  // Opcode decode: byte count, and the shape of the bus cycle it launches
  logic [2:0]        need;
  logic              bus_op;
  logic              op_rd;
  logic [ADDR_W-1:0] op_addr;
  logic [7:0]        op_data;

  always_comb begin
    need    = 3'd1;
    bus_op  = 1'b0;
    op_rd   = (r.cmd[0] == OP_R);
    op_addr = a24[ADDR_W-1:0];
    op_data = r.cmd[4];
    case (r.cmd[0])
      OP_W: begin need = 3'd5; bus_op = 1'b1; end
      OP_R: begin need = 3'd4; bus_op = 1'b1; end
`ifdef USB_BUS_MASTER_AUTOINC_EN
      OP_N: begin
        need    = last_w ? 3'd2 : 3'd1;
        bus_op  = 1'b1;
        op_rd   = !last_w;
        op_addr = last_addr + ADDR_W'(1);
        op_data = r.cmd[1];
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) r <= R_RST;
    else         r <= rn;
  end

  always_comb begin
    rn = r;
    case (r.state)
      IDLE: begin
        if (!rdf_s) begin
          rn.state = FETCH;
          rn.phase = P_PULSE;
          rn.rd_n  = 1'b0;
          rn.cnt   = CNT_W'(1);
          rn.bidx  = 3'd0;
        end
      end

      FETCH: begin
        case (r.phase)
          P_WAIT: begin
            if (!rdf_s) begin
              rn.phase = P_PULSE;
              rn.rd_n  = 1'b0;
              rn.cnt   = CNT_W'(1);
            end
          end
          P_PULSE: begin
            // FIFO data is sampled on the last clock of the _rd pulse
            if (r.cnt == CNT_W'(RD_PULSE)) begin
              rn.cmd[r.bidx] = u.usb_din;
              rn.bidx        = r.bidx + 3'd1;
              rn.rd_n        = 1'b1;
              rn.cnt         = CNT_W'(1);
              rn.phase       = P_GAP;
            end else begin
              rn.cnt = r.cnt + 1'b1;
            end
          end
          default: begin // P_GAP
            if (r.cnt == CNT_W'(SYNC_GAP)) begin
              if (r.bidx == need) begin
                if (bus_op) begin
                  rn.state   = REQ;
                  rn.bus_req = 1'b1;
                end else begin
                  rn.state = SEND;
                  rn.phase = P_WAIT;
                  rn.rep0  = ST_BAD;
                  rn.two   = 1'b0;
                  rn.ridx  = 1'b0;
                end
              end else begin
                rn.phase = P_WAIT;
              end
            end else begin
              rn.cnt = r.cnt + 1'b1;
            end
          end
        endcase
      end

      REQ: begin
        if (gnt_s) begin
          rn.state    = ADDR;
          rn.addr     = op_addr;
          rn.rw       = op_rd;
          rn.bus_dout = op_rd ? r.bus_dout : op_data;
          rn.bus_doe  = !op_rd;
          rn.as_n     = 1'b0;
        end
      end

      ADDR: begin
        rn.state = STROBE;
        rn.ds_n  = 1'b0;
        rn.cnt   = CNT_W'(1);
      end

      STROBE: begin
        if (!dtack_s) begin
          if (r.rw) rn.rdata = u.bus_din;
          rn.tout    = 1'b0;
          rn.state   = RELEASE;
          rn.as_n    = 1'b1;
          rn.ds_n    = 1'b1;
          rn.bus_doe = 1'b0;
        end else if (r.cnt == CNT_W'(DTACK_TIMEOUT)) begin
          rn.err     = 1'b1;
          rn.tout    = 1'b1;
          rn.rdata   = 8'h00;
          rn.state   = RELEASE;
          rn.as_n    = 1'b1;
          rn.ds_n    = 1'b1;
          rn.bus_doe = 1'b0;
        end else begin
          rn.cnt = r.cnt + 1'b1;
        end
      end

      RELEASE: begin
        rn.bus_req = 1'b0;
        rn.rw      = 1'b1;
        rn.state   = SEND;
        rn.phase   = P_WAIT;
        rn.rep0    = r.tout ? ST_TO : ST_OK;
        rn.two     = r.rw;
        rn.ridx    = 1'b0;
      end

      SEND: begin
        case (r.phase)
          P_WAIT: begin
            if (!txe_s) begin
              rn.usb_dout = r.ridx ? r.rdata : r.rep0;
              rn.usb_doe  = 1'b1;
              rn.phase    = P_SETUP;
            end
          end
          P_SETUP: begin
            rn.wr    = 1'b1;
            rn.cnt   = CNT_W'(1);
            rn.phase = P_PULSE;
          end
          P_PULSE: begin
            // The FIFO latches on the falling edge of wr; data stays one more clock
            if (r.cnt == CNT_W'(WR_PULSE)) begin
              rn.wr    = 1'b0;
              rn.phase = P_HOLD;
            end else begin
              rn.cnt = r.cnt + 1'b1;
            end
          end
          P_HOLD: begin
            rn.usb_doe  = 1'b0;
            rn.usb_dout = 8'h00;
            if (r.ridx == r.two) begin
              rn.state = IDLE;
              rn.phase = P_WAIT;
            end else begin
              rn.ridx  = 1'b1;
              rn.cnt   = CNT_W'(1);
              rn.phase = P_GAP;
            end
          end
          default: begin // P_GAP
            if (r.cnt == CNT_W'(SYNC_GAP)) rn.phase = P_WAIT;
            else                           rn.cnt   = r.cnt + 1'b1;
          end
        endcase
      end

      default: rn = R_RST;
    endcase
  end

`ifdef USB_BUS_MASTER_AUTOINC_EN
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      last_w    <= 1'b0;
      last_addr <= '1;
    end else if (r.state == REQ && rn.state == ADDR) begin
      last_w    <= !rn.rw;
      last_addr <= rn.addr;
    end
  end
`endif

  assign u._rd      = r.rd_n;
  assign u.wr       = r.wr;
  assign u.usb_doe  = r.usb_doe;
  assign u.usb_dout = r.usb_dout;
  assign u.bus_req  = r.bus_req;
  assign u.addr     = r.addr;
  assign u.bus_dout = r.bus_dout;
  assign u.bus_doe  = r.bus_doe;
  assign u._as      = r.as_n;
  assign u._ds      = r.ds_n;
  assign u.rw       = r.rw;
  assign busy       = (r.state != IDLE);
  assign err        = r.err;

endmodule

// File: tb/tb_usb_bus_master.sv
// tb_usb_bus_master
//   Directed bench for usb_bus_master. The bench provides three models:
//     - a host FIFO array that is popped on each rising _rd
//   	- a reply capture that samples usb_dout on each falling wr
//     - a bus responder that asserts _dtack a set number of clocks into _ds low
//   The stimulus is a linear series of commands. Each command is followed by
//   checks against hand-derived expected values.
module tb_usb_bus_master;
  logic clk = 1'b0;
  logic _reset;
  logic busy, err;

  always #5 clk = ~clk;

  usb_bus_master_if #(.ADDR_W(20)) bif ();

  usb_bus_master #(.ADDR_W(20), .DTACK_TIMEOUT(255), .RD_PULSE(2), .WR_PULSE(2)) dut (
    .clk   (clk),
    ._reset(_reset),
    .u     (bif),
    .busy  (busy),
    .err   (err)
  );

  int checks = 0;
  int errors = 0;

  // Host -> device FIFO
  logic [7:0] fifo_mem [0:63];
  int head = 0;
  int tail = 0;
  assign bif._rdf    = (head == tail);
  assign bif.usb_din = fifo_mem[head[5:0]];

  always @(posedge bif._rd) if (head != tail) head = head + 1;

  // Device -> host replies
  logic [7:0] tx_mem [0:63];
  int tx_cnt  = 0;
  int doe_bad = 0;
  always @(negedge bif.wr) begin
    if (_reset === 1'b1 && tx_cnt < 64) begin
      tx_mem[tx_cnt] = bif.usb_dout;
      if (bif.usb_doe !== 1'b1) doe_bad = doe_bad + 1;
      tx_cnt = tx_cnt + 1;
    end
  end

  // Bus responder; dly < 0 means never acknowledge
  int          dly      = 3;
  int          ds_cnt   = 0;
  int          ds_clks  = 0;
  int          as_cnt   = 0;
  logic        as_prev  = 1'b1;
  logic [19:0] cap_addr = '0;
  logic        cap_rw   = 1'b1;
  logic        cap_doe  = 1'b0;
  logic [7:0]  cap_dout = '0;

  always @(negedge clk) begin
    if (bif._as === 1'b0 && as_prev === 1'b1) as_cnt = as_cnt + 1;
    as_prev = bif._as;
    if (bif._ds === 1'b0) begin
      ds_clks  = ds_clks + 1;
      cap_addr = bif.addr;
      cap_rw   = bif.rw;
      cap_dout = bif.bus_dout;
      cap_doe  = bif.bus_doe;
      if (dly >= 0 && ds_cnt >= dly) bif._dtack = 1'b0;
      ds_cnt = ds_cnt + 1;
    end else begin
      ds_cnt     = 0;
      bif._dtack = 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    fifo_mem[tail[5:0]] = b;
    tail = tail + 1;
  endtask

  task automatic wait_tx(input int n, input string tag);
    for (int i = 0; i < 3000 && tx_cnt < n; i++) @(negedge clk);
    check(tag, 32'(tx_cnt >= n), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 3000 && busy !== 1'b0; i++) @(negedge clk);
    check(tag, 32'(busy), 32'd0);
  endtask

  // All outputs at their inactive values
  task automatic chk_outs(input string tag);
    check({tag, "_ctl"},
          32'({bif._rd, bif.wr, bif.usb_doe, bif.usb_dout, bif.bus_req, bif.bus_doe,
               bif._as, bif._ds, bif.rw, busy, err}),
          32'({1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}));
    check({tag, "_addr"}, 32'(bif.addr), 32'h0);
    check({tag, "_bdout"}, 32'(bif.bus_dout), 32'h0);
  endtask

  initial begin
    int base, a0, d0, wr_hi;
    _reset      = 1'b0;
    bif._txe    = 1'b0;
    bif.bus_gnt = 1'b1;
    bif.bus_din = 8'h00;
    repeat (3) @(negedge clk);
    chk_outs("reset");
    _reset = 1'b1;
    repeat (3) @(negedge clk);

    // Write 0xAB to 0x01234
    base = tx_cnt; a0 = as_cnt;
    push(8'h57); push(8'h00); push(8'h12); push(8'h34); push(8'hAB);
    wait_tx(base + 1, "wr_reply_seen");
    wait_idle("wr_idle");
    check("wr_as_count", 32'(as_cnt - a0), 32'd1);
    check("wr_addr", 32'(cap_addr), 32'h01234);
    check("wr_rw", 32'(cap_rw), 32'd0);
    check("wr_dout", 32'(cap_dout), 32'hAB);
    check("wr_doe", 32'(cap_doe), 32'd1);
    check("wr_status", 32'(tx_mem[base]), 32'h06);
    check("wr_err", 32'(err), 32'd0);
    check("wr_fifo_drained", 32'(head), 32'(tail));

    // Read from 0x80000
    base = tx_cnt; bif.bus_din = 8'h5A;
    push(8'h52); push(8'h08); push(8'h00); push(8'h00);
    wait_tx(base + 2, "rd_reply_seen");
    wait_idle("rd_idle");
    check("rd_addr", 32'(cap_addr), 32'h80000);
    check("rd_rw", 32'(cap_rw), 32'd1);
    check("rd_doe", 32'(cap_doe), 32'd0);
    check("rd_status", 32'(tx_mem[base]), 32'h06);
    check("rd_data", 32'(tx_mem[base + 1]), 32'h5A);
    check("rd_err", 32'(err), 32'd0);

    // Timeout: _ds low exactly 255 clocks, replies 15 00, err sticks
    base = tx_cnt; dly = -1; d0 = ds_clks;
    push(8'h52); push(8'h00); push(8'h00); push(8'h01);
    wait_tx(base + 2, "to_reply_seen");
    wait_idle("to_idle");
    check("to_ds_clocks", 32'(ds_clks - d0), 32'd255);
    check("to_status", 32'(tx_mem[base]), 32'h15);
    check("to_data", 32'(tx_mem[base + 1]), 32'h00);
    check("to_err", 32'(err), 32'd1);
    dly = 3;
    base = tx_cnt;
    push(8'h57); push(8'h00); push(8'h00); push(8'h20); push(8'h5E);
    wait_tx(base + 1, "to2_reply_seen");
    wait_idle("to2_idle");
    check("to2_status", 32'(tx_mem[base]), 32'h06);
    check("to2_err_sticky", 32'(err), 32'd1);

    // Flow control: _txe held high blocks the reply
    base = tx_cnt; a0 = as_cnt; bif._txe = 1'b1;
    push(8'h57); push(8'h00); push(8'h00); push(8'h10); push(8'hC3);
    for (int i = 0; i < 500 && as_cnt == a0; i++) @(negedge clk);
    check("fc_cycle_started", 32'(as_cnt - a0), 32'd1);
    repeat (10) @(negedge clk);
    wr_hi = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bif.wr !== 1'b0) wr_hi = wr_hi + 1;
    end
    check("fc_wr_quiet", 32'(wr_hi), 32'd0);
    check("fc_no_reply", 32'(tx_cnt), 32'(base));
    check("fc_busy", 32'(busy), 32'd1);
    bif._txe = 1'b0;
    wait_tx(base + 1, "fc_reply_seen");
    wait_idle("fc_idle");
    check("fc_status", 32'(tx_mem[base]), 32'h06);
    check("fc_addr", 32'(cap_addr), 32'h00010);
    check("fc_dout", 32'(cap_dout), 32'hC3);

    // Grant withheld: no _as, no read-ahead; then an unknown opcode follows
    base = tx_cnt; a0 = as_cnt; bif.bus_gnt = 1'b0; bif.bus_din = 8'h99;
    push(8'h52); push(8'h00); push(8'h00); push(8'h07); push(8'h3A);
    repeat (60) @(negedge clk);
    check("gnt_no_as", 32'(as_cnt - a0), 32'd0);
    check("gnt_req", 32'(bif.bus_req), 32'd1);
    check("gnt_no_readahead", 32'(tail - head), 32'd1);
    bif.bus_gnt = 1'b1;
    wait_tx(base + 3, "gnt_reply_seen");
    wait_idle("gnt_idle");
    check("gnt_addr", 32'(cap_addr), 32'h00007);
    check("gnt_status", 32'(tx_mem[base]), 32'h06);
    check("gnt_data", 32'(tx_mem[base + 1]), 32'h99);
    check("bad_op_reply", 32'(tx_mem[base + 2]), 32'h3F);
    check("bad_op_no_as", 32'(as_cnt - a0), 32'd1);

`ifndef USB_BUS_MASTER_AUTOINC_EN
    base = tx_cnt; a0 = as_cnt;
    push(8'h4E);
    wait_tx(base + 1, "n_reply_seen");
    wait_idle("n_idle");
    check("n_unknown_reply", 32'(tx_mem[base]), 32'h3F);
    check("n_no_as", 32'(as_cnt - a0), 32'd0);
`endif

    // Reset while in STROBE
    dly = -1;
    push(8'h52); push(8'h00); push(8'h00); push(8'h02);
    for (int i = 0; i < 500 && bif._ds !== 1'b0; i++) @(negedge clk);
    check("rst_in_strobe", 32'(bif._ds), 32'd0);
    repeat (5) @(negedge clk);
    #2 _reset = 1'b0;
    #1 chk_outs("mid_reset");
    base = tx_cnt;
    repeat (3) @(negedge clk);
    _reset = 1'b1;
    dly = 3;
    repeat (30) @(negedge clk);
    check("rst_no_reply", 32'(tx_cnt), 32'(base));

`ifdef USB_BUS_MASTER_AUTOINC_EN
    base = tx_cnt; bif.bus_din = 8'h42;
    push(8'h4E);
    wait_tx(base + 2, "n0_reply_seen");
    wait_idle("n0_idle");
    check("n0_addr", 32'(cap_addr), 32'h00000);
    check("n0_rw", 32'(cap_rw), 32'd1);
    check("n0_data", 32'(tx_mem[base + 1]), 32'h42);
`endif

    // After reset: write at the top address, A2[7:4] ignored
    base = tx_cnt;
    push(8'h57); push(8'hFF); push(8'hFF); push(8'hFF); push(8'h11);
    wait_tx(base + 1, "post_rst_reply_seen");
    wait_idle("post_rst_idle");
    check("post_rst_addr", 32'(cap_addr), 32'hFFFFF);
    check("post_rst_dout", 32'(cap_dout), 32'h11);
    check("post_rst_status", 32'(tx_mem[base]), 32'h06);
    check("post_rst_err", 32'(err), 32'd0);

`ifdef USB_BUS_MASTER_AUTOINC_EN
    base = tx_cnt;
    push(8'h4E); push(8'h77);
    wait_tx(base + 1, "nw_reply_seen");
    wait_idle("nw_idle");
    check("nw_addr_wrap", 32'(cap_addr), 32'h00000);
    check("nw_dout", 32'(cap_dout), 32'h77);
    check("nw_rw", 32'(cap_rw), 32'd0);
    check("nw_status", 32'(tx_mem[base]), 32'h06);
`endif

    check("doe_at_wr_fall", 32'(doe_bad), 32'd0);
    check("fifo_drained_end", 32'(head), 32'(tail));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
